face_color_sampler: RTL and testbench
=====================================

# face_color_sampler

Upstream stage of the face-colour RAM: consumes the camera's RGB565 pixel stream for one frame, averages a WIN×WIN window at the centre of each of the 9 stickers of a cube face, classifies each average into a colour code, and writes the 9 codes into the 3×3 face RAM through its write port. The controller starts one capture per face with `start` and waits for `done`.

## Interface
- WIDTH, 320: pixels per line.
- HEIGHT, 240: lines per frame.
- X0, 100: x of the left edge of column-0 windows.
- Y0, 60: y of the top edge of line-0 windows.
- PITCH, 60: distance in pixels/lines between adjacent window origins; must be ≥ WIN+1.
- WIN, 4: window side; power of two (2, 4, 8).
- HI, 40: "high" threshold on 6-bit channel averages.
- MID, 20: "mid" threshold on 6-bit channel averages.
- S_DATA, 3: colour code width.
- S_LINE, 2 / S_COLUMN, 2: RAM address widths.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a capture.
- frame_start  in  1  one-cycle pulse marking the first pixel of a frame (derived from vsync).
- pixel_valid  in  1  `pixel` is valid this cycle.
- pixel  in  16  RGB565: R=[15:11], G=[10:5], B=[4:0].
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse after the 9th write.
- we  out  1  RAM write enable.
- addr_line  out  S_LINE  RAM line (0..2).
- addr_column  out  S_COLUMN  RAM column (0..2).
- data  out  S_DATA  colour code.

## Operation
- States:
  - IDLE: `start` → ARMED.
  - ARMED: `frame_start` → CAPTURE, with x=y=0 and accumulators zeroed.
  - CAPTURE: accumulates pixels; leaves for WRITE after the last pixel of the last window line of the current band.
  - WRITE: 3 cycles, columns 0,1,2 of the current band. Then returns to CAPTURE if band<2; otherwise goes to DONE.
  - DONE: 1 cycle with `done`=1, then IDLE.
- Pixel position: each `pixel_valid` advances x; when x reaches WIDTH-1 it wraps to 0 and y increments. The counters run in CAPTURE and WRITE.
- Band b covers y in [Y0+b·PITCH, Y0+b·PITCH+WIN-1]. Column c covers x in [X0+c·PITCH, X0+c·PITCH+WIN-1].
- Accumulators: 3 per channel, one per column, so 9 in total. Widths are 5+2·log2(WIN) for R/B and 6+2·log2(WIN) for G.
- Averages are sums >> 2·log2(WIN). R and B averages are then shifted left by 1 to give 6-bit r, g, b.
- Classification, first match wins:
  - r≥HI, g≥HI, b≥HI → 0 white
  - r≥HI, g≥HI → 1 yellow
  - r≥HI, g≥MID → 3 orange
  - r≥HI → 2 red
  - g≥b → 4 green
  - else → 5 blue
- Write order: (0,0),(0,1),(0,2),(1,0)…(2,2), i.e. `addr_line`=band, `addr_column`=column.
- The band's accumulators are zeroed in the last WRITE cycle.
- Pixels arriving during WRITE advance x/y but are not accumulated. PITCH ≥ WIN+1 guarantees they lie outside every window.
- Edge cases:
  - `start` while busy: ignored.
  - `frame_start` in CAPTURE or WRITE: capture restarts (x=y=0, accumulators zeroed, band=0). RAM entries already written stay.
  - `frame_start` and `start` together in IDLE: only `start` takes effect; the next `frame_start` begins capture.
  - `clear` at any time: IDLE, all counters and accumulators zero, all outputs 0.

## Timing
- Reset values: busy=0, done=0, we=0, addr_line=0, addr_column=0, data=0.
- Outputs are registered.
- `we` is high for exactly 3 consecutive cycles per band. `addr`/`data` are valid in the same cycles; outside WRITE, we=0.
- The first WRITE cycle is the cycle after the accepting edge of the band's last window pixel. Classification is combinational from the accumulators into the registered outputs.
- `done` rises the cycle after the 9th `we` cycle. `busy` falls in the same cycle that `done` rises.
- Latency from `start` to `busy`=1: 1 cycle.

## Test plan
- Uniform frame with pixel=0xFFFF, defaults → 9 writes, all data=0, addresses in raster order; `done` once, one cycle after the 9th write.
- Per-sticker colours: centre (1,1)=0xF800, (0,2)=0x07E0, (2,0)=0x001F, (2,2)=0xFC00, rest 0xFFE0 → code 2 at (1,1), 4 at (0,2), 5 at (2,0), 3 at (2,2), 1 elsewhere.
- Only window pixels altered to 0xF800 while all non-window pixels are 0x001F → all codes 2, which proves out-of-window pixels are excluded.
- `frame_start` pulsed mid-band-1, new frame all 0x07E0 → subsequent writes are all code 4; `done` only after a full 9-write sequence.
- `clear` asserted during band-1 WRITE → all outputs 0 next edge; a later `frame_start` without `start` produces no writes.
- `start` pulsed while busy, and pixel_valid with gaps (every 3rd cycle) → no effect on result; same codes as the gapless run.

Source files
------------

// File: rtl/face_color_sampler.sv
// face_color_sampler
// Reads the camera's RGB565 pixel stream for one frame. It averages a WIN x WIN
// window at the centre of each of the 9 stickers of a cube face, turns each
// average into a colour code, and writes the 9 codes into the 3x3 face RAM.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   clear        asynchronous, active-high reset
//   start        one-cycle pulse; arms a capture (ignored while busy)
//   frame_start  one-cycle pulse marking the start of a frame
//   pixel_valid  pixel is valid this cycle
//   pixel        RGB565 pixel, R=[15:11] G=[10:5] B=[4:0]
//   busy         high from the cycle after start until done
//   done         one-cycle pulse after the 9th RAM write
//   we           RAM write enable (three cycles per band)
//   addr_line    RAM line (band 0..2)
//   addr_column  RAM column (0..2)
//   data         colour code
module face_color_sampler #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int X0       = 100,
  parameter int Y0       = 60,
  parameter int PITCH    = 60,
  parameter int WIN      = 4,
  parameter int HI       = 40,
  parameter int MID      = 20,
  parameter int S_DATA   = 3,
  parameter int S_LINE   = 2,
  parameter int S_COLUMN = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic                frame_start,
  input  logic                pixel_valid,
  input  logic [15:0]         pixel,
  output logic                busy,
  output logic                done,
  output logic                we,
  output logic [S_LINE-1:0]   addr_line,
  output logic [S_COLUMN-1:0] addr_column,
  output logic [S_DATA-1:0]   data
);

  localparam int SH = 2 * $clog2(WIN);  // log2 of the pixel count per window
  localparam int RW = 5 + SH;           // R/B accumulator width
  localparam int GW = 6 + SH;           // G accumulator width
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [S_DATA-1:0] C_WHITE  = S_DATA'(0);
  localparam logic [S_DATA-1:0] C_YELLOW = S_DATA'(1);
  localparam logic [S_DATA-1:0] C_RED    = S_DATA'(2);
  localparam logic [S_DATA-1:0] C_ORANGE = S_DATA'(3);
  localparam logic [S_DATA-1:0] C_GREEN  = S_DATA'(4);
  localparam logic [S_DATA-1:0] C_BLUE   = S_DATA'(5);

  logic [2:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    band;
  logic [1:0]    col;       // column being written during WRITE
  logic [1:0]    next_col;
  logic [RW-1:0] acc_r [3];
  logic [GW-1:0] acc_g [3];
  logic [RW-1:0] acc_b [3];

  // Window decode for the current pixel position.
  logic [15:0] x_ext, y_ext, band_y0;
  logic        in_band, last_pixel;
  logic [2:0]  col_hit;

  // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
  always_comb begin
    x_ext   = 16'(x);
    y_ext   = 16'(y);
    band_y0 = 16'(Y0) + 16'(PITCH) * 16'(band);
    in_band = (y_ext >= band_y0) && (y_ext < band_y0 + 16'(WIN));
    for (int c = 0; c < 3; c++) begin
      col_hit[c] = (x_ext >= 16'(X0 + c * PITCH)) && (x_ext < 16'(X0 + c * PITCH + WIN));
    end
    // Last pixel of the band: bottom-right corner of the column-2 window.
    last_pixel = pixel_valid && (y_ext == band_y0 + 16'(WIN - 1)) &&
                 (x_ext == 16'(X0 + 2 * PITCH + WIN - 1));
  end

  function automatic logic [S_DATA-1:0] classify(input logic [5:0] r, input logic [5:0] g,
                                                 input logic [5:0] b);
    if (r >= 6'(HI) && g >= 6'(HI) && b >= 6'(HI)) return C_WHITE;
    if (r >= 6'(HI) && g >= 6'(HI))                return C_YELLOW;
    if (r >= 6'(HI) && g >= 6'(MID))               return C_ORANGE;
    if (r >= 6'(HI))                               return C_RED;
    if (g >= b)                                    return C_GREEN;
    return C_BLUE;
  endfunction

  // Averages are the sums shifted down. The 5-bit R/B averages are then
  // scaled to the 6-bit range of G.
  logic [S_DATA-1:0] code [3];
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      code[c] = classify({5'(acc_r[c] >> SH), 1'b0},
                         6'(acc_g[c] >> SH),
                         {5'(acc_b[c] >> SH), 1'b0});
    end
  end

  assign next_col = col + 2'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      band        <= '0;
      col         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      we          <= 1'b0;
      addr_line   <= '0;
      addr_column <= '0;
      data        <= '0;
      // NOTE: the accumulators are a handful of flops that must start from zero, so they are reset
      // here, unlike a RAM array.
      for (int c = 0; c < 3; c++) begin
        acc_r[c] <= '0;
        acc_g[c] <= '0;
        acc_b[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end

        ST_ARMED: begin
          // The pixel in the frame_start cycle is not counted. The next valid pixel is (0,0).
          if (frame_start) begin
            state <= ST_CAPTURE;
            x     <= '0;
            y     <= '0;
            band  <= '0;
            for (int c = 0; c < 3; c++) begin
              acc_r[c] <= '0;
              acc_g[c] <= '0;
              acc_b[c] <= '0;
            end
          end
        end

        ST_CAPTURE, ST_WRITE: begin
          if (frame_start) begin
            // Restart the capture. RAM entries already written are kept.
            state <= ST_CAPTURE;
            x     <= '0;
            y     <= '0;
            band  <= '0;
            col   <= '0;
            we    <= 1'b0;
            for (int c = 0; c < 3; c++) begin
              acc_r[c] <= '0;
              acc_g[c] <= '0;
              acc_b[c] <= '0;
            end
          end else begin
            if (pixel_valid) begin
              if (x == XW'(WIDTH - 1)) begin
                x <= '0;
                y <= (y == YW'(HEIGHT - 1)) ? '0 : y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end

            if (state == ST_CAPTURE) begin
              if (pixel_valid && in_band) begin
                for (int c = 0; c < 3; c++) begin
                  if (col_hit[c]) begin
                    acc_r[c] <= acc_r[c] + RW'(pixel[15:11]);
                    acc_g[c] <= acc_g[c] + GW'(pixel[10:5]);
                    acc_b[c] <= acc_b[c] + RW'(pixel[4:0]);
                  end
                end
              end
              // Column 0 finished long before the band's last pixel, so its
              // code can be registered on this same edge.
              if (last_pixel) begin
                state       <= ST_WRITE;
                col         <= '0;
                we          <= 1'b1;
                addr_line   <= S_LINE'(band);
                addr_column <= '0;
                data        <= code[0];
              end
            end else begin
              if (col == 2'd2) begin
                we  <= 1'b0;
                col <= '0;
                for (int c = 0; c < 3; c++) begin
                  acc_r[c] <= '0;
                  acc_g[c] <= '0;
                  acc_b[c] <= '0;
                end
                if (band == 2'd2) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  state <= ST_CAPTURE;
                  band  <= band + 2'd1;
                end
              end else begin
                col         <= next_col;
                addr_column <= S_COLUMN'(next_col);
                data        <= code[next_col];
              end
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_face_color_sampler.sv
// Testbench for face_color_sampler. It uses a reduced frame geometry so that
// each frame stays short. Each table vector gives per-sticker window colours
// and hand-computed codes. Hand-written sequences cover restart on
// frame_start and clear during a WRITE.
module tb_face_color_sampler;

  localparam int P_WIDTH  = 32;
  localparam int P_HEIGHT = 24;
  localparam int P_X0     = 4;
  localparam int P_Y0     = 3;
  localparam int P_PITCH  = 8;
  localparam int P_WIN    = 4;
  localparam int NPIX     = P_WIDTH * P_HEIGHT;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [15:0] pixel = '0;
  logic        busy, done, we;
  logic [1:0]  addr_line, addr_column;
  logic [2:0]  data;

  face_color_sampler #(
    .WIDTH(P_WIDTH), .HEIGHT(P_HEIGHT), .X0(P_X0), .Y0(P_Y0), .PITCH(P_PITCH), .WIN(P_WIN),
    .HI(40), .MID(20), .S_DATA(3), .S_LINE(2), .S_COLUMN(2)
  ) dut (
    .clk(clk), .clear(clear), .start(start), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel(pixel), .busy(busy), .done(done), .we(we),
    .addr_line(addr_line), .addr_column(addr_column), .data(data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][15:0] color;  // window colour per sticker, index line*3+column
    logic [8:0][15:0] alt;    // colour on odd (x+y) window pixels
    logic [15:0]      bg;     // colour outside every window
    logic [8:0][2:0]  exp;    // expected code per sticker
    bit               gap;    // pixel_valid every 3rd cycle plus a stray start
  } vec_t;

  vec_t tbl [5];

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor log of RAM writes and done pulses, sampled on the falling edge.
  int         cyc = 0;
  logic [6:0] wlog [128];
  int         wcyc [128];
  int         wcount = 0;
  int         dcount = 0;
  int         dcyc = 0;
  logic       done_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wlog[wcount] = {addr_line, addr_column, data};
      wcyc[wcount] = cyc;
      if (wcount < 127) wcount++;
    end
    if (done) begin
      dcount++;
      dcyc      = cyc;
      done_busy = busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  function automatic logic [15:0] pix_at(input int vi, input int px, input int py);
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 3; c++) begin
        if (py >= P_Y0 + b * P_PITCH && py < P_Y0 + b * P_PITCH + P_WIN &&
            px >= P_X0 + c * P_PITCH && px < P_X0 + c * P_PITCH + P_WIN) begin
          return ((px + py) % 2 == 1) ? tbl[vi].alt[b * 3 + c] : tbl[vi].color[b * 3 + c];
        end
      end
    end
    return tbl[vi].bg;
  endfunction

  // Streams npix pixels in raster order starting at (0,0). vi < 0 sends 'fill'.
  task automatic stream(input int vi, input logic [15:0] fill, input int npix, input bit gap);
    int px = 0;
    int py = 0;
    int sent = 0;
    int phase = 0;
    while (sent < npix) begin
      start = 1'b0;
      if (gap && (phase % 3 != 0)) begin
        pixel_valid = 1'b0;
        pixel       = 16'($urandom);
        if (phase == 3 * P_WIDTH * 5 + 1) start = 1'b1;  // stray start while busy
      end else begin
        pixel_valid = 1'b1;
        pixel       = (vi >= 0) ? pix_at(vi, px, py) : fill;
        sent++;
        px++;
        if (px == P_WIDTH) begin
          px = 0;
          py++;
        end
      end
      phase++;
      tick();
    end
    pixel_valid = 1'b0;
    start       = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    check({tag, " busy_before_start"}, 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    pixel_valid = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  // Checks 9 writes starting at log index w0 against codes e.
  task automatic verify9(input string tag, input int w0, input logic [8:0][2:0] e);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s write%0d {line,col,data}", tag, k), 32'(wlog[w0 + k]),
            32'({2'(k / 3), 2'(k % 3), e[k]}));
    end
    for (int b = 0; b < 3; b++) begin
      check($sformatf("%s band%0d we contiguous", tag, b),
            32'(wcyc[w0 + 3 * b + 2] - wcyc[w0 + 3 * b]), 32'd2);
    end
    check({tag, " done one cycle after 9th write"}, 32'(dcyc), 32'(wcyc[w0 + 8] + 1));
    check({tag, " busy low with done"}, 32'(done_busy), 32'd0);
  endtask

  initial begin
    int w0, d0;
    logic [8:0][2:0] e;
    bit found;

    // Vector table.
    for (int i = 0; i < 5; i++) begin
      tbl[i].bg  = '0;
      tbl[i].gap = 1'b0;
    end
    // Uniform white.
    tbl[0].color = {9{16'hFFFF}};
    tbl[0].bg    = 16'hFFFF;
    tbl[0].exp   = {9{3'd0}};
    // Per-sticker colours on a yellow face.
    tbl[1].color    = {9{16'hFFE0}};
    tbl[1].color[4] = 16'hF800;
    tbl[1].color[2] = 16'h07E0;
    tbl[1].color[6] = 16'h001F;
    tbl[1].color[8] = 16'hFC00;
    tbl[1].bg       = 16'hFFE0;
    tbl[1].exp      = {9{3'd1}};
    tbl[1].exp[4]   = 3'd2;
    tbl[1].exp[2]   = 3'd4;
    tbl[1].exp[6]   = 3'd5;
    tbl[1].exp[8]   = 3'd3;
    // Red windows in a blue frame: out-of-window pixels must be ignored.
    tbl[2].color = {9{16'hF800}};
    tbl[2].bg    = 16'h001F;
    tbl[2].exp   = {9{3'd2}};
    // Threshold edges and checkerboard averaging.
    tbl[3].color[0] = rgb(20, 40, 20);  tbl[3].exp[0] = 3'd0;  // all exactly HI
    tbl[3].color[1] = rgb(20, 40, 19);  tbl[3].exp[1] = 3'd1;  // b = 38
    tbl[3].color[2] = rgb(20, 39, 0);   tbl[3].exp[2] = 3'd3;  // g just under HI
    tbl[3].color[3] = rgb(20, 19, 0);   tbl[3].exp[3] = 3'd2;  // g just under MID
    tbl[3].color[4] = rgb(19, 10, 5);   tbl[3].exp[4] = 3'd4;  // r = 38, g == b
    tbl[3].color[5] = rgb(19, 10, 6);   tbl[3].exp[5] = 3'd5;  // b > g
    tbl[3].color[6] = rgb(20, 20, 0);   tbl[3].exp[6] = 3'd3;  // g exactly MID
    tbl[3].color[7] = 16'hF800;         tbl[3].exp[7] = 3'd4;  // r avg 15 -> 30
    tbl[3].color[8] = 16'hFFFF;         tbl[3].exp[8] = 3'd3;  // g avg 31, b avg 15
    tbl[3].bg       = 16'h0000;
    // Same as vector 1, with gaps in pixel_valid and a stray start.
    tbl[4]     = tbl[1];
    tbl[4].gap = 1'b1;
    for (int i = 0; i < 5; i++) tbl[i].alt = tbl[i].color;
    tbl[3].alt[7] = 16'h0000;
    tbl[3].alt[8] = 16'hF800;

    // Reset values.
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset we", 32'(we), 32'd0);
    check("reset addr_line", 32'(addr_line), 32'd0);
    check("reset addr_column", 32'(addr_column), 32'd0);
    check("reset data", 32'(data), 32'd0);
    clear = 1'b0;
    tick();

    // Table-driven frames.
    for (int vi = 0; vi < 5; vi++) begin
      string tag;
      tag = $sformatf("vec%0d", vi);
      pulse_start(tag);
      w0 = wcount;
      d0 = dcount;
      pulse_frame_start();
      stream(vi, 16'h0000, NPIX, tbl[vi].gap);
      repeat (4) tick();
      check({tag, " write count"}, 32'(wcount - w0), 32'd9);
      check({tag, " done count"}, 32'(dcount - d0), 32'd1);
      verify9(tag, w0, tbl[vi].exp);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
    end

    // frame_start in mid-band-1: band 0 of the white frame has been written,
    // then a full green frame follows.
    pulse_start("restart");
    w0 = wcount;
    d0 = dcount;
    pulse_frame_start();
    stream(0, 16'h0000, P_WIDTH * 12, 1'b0);
    pulse_frame_start();
    stream(-1, 16'h07E0, NPIX, 1'b0);
    repeat (4) tick();
    check("restart write count", 32'(wcount - w0), 32'd12);
    check("restart done count", 32'(dcount - d0), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("restart early write%0d", k), 32'(wlog[w0 + k]), 32'({2'd0, 2'(k), 3'd0}));
    end
    e = {9{3'd4}};
    verify9("restart", w0 + 3, e);

    // clear during the band-1 WRITE, then a frame_start without start.
    pulse_start("clear");
    pulse_frame_start();
    found = 1'b0;
    for (int i = 0; i < NPIX && !found; i++) begin
      pixel_valid = 1'b1;
      pixel       = pix_at(0, i % P_WIDTH, i / P_WIDTH);
      tick();
      if (we && addr_line == 2'd1) found = 1'b1;
    end
    pixel_valid = 1'b0;
    check("clear reached band1 write", 32'(found), 32'd1);
    clear = 1'b1;
    tick();
    check("clear busy", 32'(busy), 32'd0);
    check("clear done", 32'(done), 32'd0);
    check("clear we", 32'(we), 32'd0);
    check("clear addr_line", 32'(addr_line), 32'd0);
    check("clear addr_column", 32'(addr_column), 32'd0);
    check("clear data", 32'(data), 32'd0);
    clear = 1'b0;
    tick();
    w0 = wcount;
    d0 = dcount;
    pulse_frame_start();
    stream(0, 16'h0000, NPIX, 1'b0);
    repeat (4) tick();
    check("no writes without start", 32'(wcount - w0), 32'd0);
    check("no done without start", 32'(dcount - d0), 32'd0);
    check("busy stays low without start", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
